// File: rtl/mul_pkg.sv
// Shared definitions for the radix-4 sequential multiplier.
package mul_pkg;

   // FSM encoding shared by the multiplier and anything that observes it.
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   // Number of 2-bit multiplier digits retired for a given operand width.
   function automatic int digits_of(input int width);
      return width / 2;
   endfunction

   // Counter width able to hold the value DIGITS (counts DIGITS down to 1).
   function automatic int cnt_width(input int width);
      return $clog2(digits_of(width) + 1);
   endfunction

endpackage

// File: rtl/mul_digit_r4.sv
// Radix-4 digit product: multiplies a full-width multiplicand by a 2-bit digit.
module mul_digit_r4 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] mcand,
   input  logic [1:0]       digit,
   output logic [WIDTH+1:0] pp
);

   // Select 0, 1x, 2x or 3x multiplicand; 3x is the only case needing an adder.
   always_comb begin
      pp = '0;
      case (digit)
         2'd0: pp = '0;
         2'd1: pp = {2'b00, mcand};
         2'd2: pp = {1'b0, mcand, 1'b0};
         2'd3: pp = {1'b0, mcand, 1'b0} + {2'b00, mcand};
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/mul_seq_r4.sv
// Iterative unsigned WIDTH x WIDTH multiplier, one radix-4 digit per clock.
module mul_seq_r4
   import mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int DIGITS = digits_of(WIDTH);
   localparam int CW     = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_INIT = CW'(DIGITS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t               state_q,   state_d;
   logic [WIDTH-1:0]     mcand_q,   mcand_d;
   logic [WIDTH-1:0]     mplr_q,    mplr_d;
   logic [2*WIDTH-1:0]   acc_q,     acc_d;
   logic [CW-1:0]        count_q,   count_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH+1:0]     pp;
   logic [2*WIDTH+1:0]   sum;
   logic [2*WIDTH-1:0]   acc_step;

   mul_digit_r4 #(.WIDTH(WIDTH)) u_digit (
      .mcand (mcand_q),
      .digit (mplr_q[1:0]),
      .pp    (pp)
   );

   // Add the digit product at the top of the accumulator and shift right by one
   // digit; the two extra sum bits keep the carry that the shift brings back in.
   always_comb begin
      sum      = {2'b00, acc_q} + {pp, {WIDTH{1'b0}}};
      acc_step = sum[2*WIDTH+1:2];
   end

   // Next-state logic: operand load, per-digit iteration and result capture.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               mcand_d = a;
               mplr_d  = b;
               acc_d   = '0;
               count_d = CNT_INIT;
            end
         end
         RUN: begin
            acc_d   = acc_step;
            mplr_d  = mplr_q >> 2;
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
               state_d   = DONE;
               product_d = acc_step;
            end
         end
         DONE: begin
            if (start) begin
               state_d = RUN;
               mcand_d = a;
               mplr_d  = b;
               acc_d   = '0;
               count_d = CNT_INIT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   // Status outputs decode directly from the registered state.
   always_comb begin
      busy    = (state_q == RUN);
      done    = (state_q == DONE);
      product = product_q;
   end

endmodule

// File: tb/tb_mul_seq_r4.sv
// Randomised self-checking bench for mul_seq_r4 at WIDTH=8 and WIDTH=6.
module tb_mul_seq_r4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start6;
   logic [7:0]  a8, b8;
   logic [5:0]  a6, b6;
   logic        busy8, done8, busy6, done6;
   logic [15:0] product8;
   logic [11:0] product6;

   logic [15:0] prev8, prev6;
   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mul_seq_r4 #(.WIDTH(8)) u_dut8 (
      .clk     (clk),
      .rst     (rst),
      .start   (start8),
      .a       (a8),
      .b       (b8),
      .busy    (busy8),
      .done    (done8),
      .product (product8)
   );

   mul_seq_r4 #(.WIDTH(6)) u_dut6 (
      .clk     (clk),
      .rst     (rst),
      .start   (start6),
      .a       (a6),
      .b       (b6),
      .busy    (busy6),
      .done    (done6),
      .product (product6)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic [7:0] av, input logic [7:0] bv);
      if (sel == 8) begin
         start8 = s; a8 = av; b8 = bv;
      end else begin
         start6 = s; a6 = av[5:0]; b6 = bv[5:0];
      end
   endtask

   function automatic logic get_busy(input int sel);
      return (sel == 8) ? busy8 : busy6;
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 8) ? done8 : done6;
   endfunction

   function automatic logic [15:0] get_prod(input int sel);
      return (sel == 8) ? product8 : {4'h0, product6};
   endfunction

   // Issue one multiply (called just after a negedge) and follow it cycle by
   // cycle: busy for exactly W/2 cycles, then a single done cycle carrying a*b.
   // junk keeps start high with fresh operands through RUN; chain issues the
   // next operands in the done cycle.
   task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                         input bit junk, input bit chain,
                         input logic [7:0] na, input logic [7:0] nb);
      logic [15:0] ea, eb, expv, prevv;
      int dig;
      dig   = sel / 2;
      ea    = (sel == 8) ? {8'h00, av} : {10'h000, av[5:0]};
      eb    = (sel == 8) ? {8'h00, bv} : {10'h000, bv[5:0]};
      expv  = ea * eb;
      prevv = (sel == 8) ? prev8 : prev6;
      drive(sel, 1'b1, av, bv);
      for (int i = 1; i <= dig; i++) begin
         @(negedge clk);
         check("busy_run", 32'(get_busy(sel)), 32'd1);
         check("done_run", 32'(get_done(sel)), 32'd0);
         check("prod_held", 32'(get_prod(sel)), 32'(prevv));
         drive(sel, junk, 8'($urandom), 8'($urandom));
      end
      @(negedge clk);
      check("done_pulse", 32'(get_done(sel)), 32'd1);
      check("busy_done", 32'(get_busy(sel)), 32'd0);
      check("product", 32'(get_prod(sel)), 32'(expv));
      if (sel == 8) prev8 = expv; else prev6 = expv;
      if (chain) begin
         drive(sel, 1'b1, na, nb);
      end else begin
         drive(sel, 1'b0, 8'h00, 8'h00);
         @(negedge clk);
         check("done_after", 32'(get_done(sel)), 32'd0);
         check("busy_after", 32'(get_busy(sel)), 32'd0);
         check("prod_after", 32'(get_prod(sel)), 32'(expv));
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(8, 1'b0, 8'h00, 8'h00);
      drive(6, 1'b0, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      // Reset beats a simultaneous start.
      drive(8, 1'b1, 8'h0F, 8'h0F);
      drive(6, 1'b1, 8'h0F, 8'h0F);
      @(negedge clk);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_prod8", 32'(product8), 32'd0);
      check("rst_busy6", 32'(busy6), 32'd0);
      check("rst_done6", 32'(done6), 32'd0);
      check("rst_prod6", 32'(product6), 32'd0);
      rst = 1'b0;
      drive(8, 1'b0, 8'h00, 8'h00);
      drive(6, 1'b0, 8'h00, 8'h00);
      prev8 = 16'h0000;
      prev6 = 16'h0000;
      @(negedge clk);
      check("idle_busy8", 32'(busy8), 32'd0);

      // Directed WIDTH=8 cases.
      run_op(8, 8'h0F, 8'h0F, 1'b0, 1'b0, 8'h00, 8'h00);
      run_op(8, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
      run_op(8, 8'h00, 8'hAB, 1'b0, 1'b0, 8'h00, 8'h00);
      run_op(8, 8'h03, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00);
      run_op(8, 8'hAB, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      // Start held high with other operands during RUN is ignored.
      run_op(8, 8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 8'h00);
      // Back-to-back: next start in the done cycle.
      run_op(8, 8'h0F, 8'h0F, 1'b0, 1'b1, 8'h10, 8'h10);
      run_op(8, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);

      // Reset in RUN cycle 2 aborts with no done pulse.
      drive(8, 1'b1, 8'h5A, 8'h77);
      @(negedge clk);
      drive(8, 1'b0, 8'h00, 8'h00);
      check("abort_busy1", 32'(busy8), 32'd1);
      @(negedge clk);
      check("abort_busy2", 32'(busy8), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_done", 32'(done8), 32'd0);
      check("abort_prod", 32'(product8), 32'd0);
      prev8 = 16'h0000;
      prev6 = 16'h0000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_nodone", 32'(done8), 32'd0);
      end
      run_op(8, 8'h5A, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);

      // Directed WIDTH=6 corners.
      run_op(6, 8'h3F, 8'h3F, 1'b0, 1'b0, 8'h00, 8'h00);
      run_op(6, 8'h00, 8'h2A, 1'b0, 1'b0, 8'h00, 8'h00);

      // Random sweeps; occasionally keep start high through RUN or chain.
      for (int w = 0; w < 2; w++) begin
         int sel;
         logic [7:0] ra, rb, na, nb;
         bit chained;
         sel = (w == 0) ? 8 : 6;
         chained = 1'b0;
         ra = 8'($urandom);
         rb = 8'($urandom);
         for (int i = 0; i < 1000; i++) begin
            bit junk, chain;
            junk  = ($urandom_range(0, 3) == 0);
            chain = ($urandom_range(0, 3) == 0) && (i != 999);
            na = 8'($urandom);
            nb = 8'($urandom);
            run_op(sel, ra, rb, junk, chain, na, nb);
            ra = na;
            rb = nb;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
